// File: rtl/mem_access_sequencer.sv
// Sequences sized MIPS loads/stores onto a byte-wide data memory, one byte per cycle,
// big-endian, with sign/zero extension of load data and rejection of bad accesses.
module mem_access_sequencer #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [31:0]       ReqAddress,
    input  logic [31:0]       ReqWriteData,
    output logic              RespValid,
    output logic [31:0]       RespData,
    output logic              RespError,
    output logic [ADDR_W-1:0] MemAddress,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [7:0]        MemWriteByte,
    input  logic [7:0]        MemReadByte
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  last_q;
    logic [31:0] wdata_q;
    logic [23:0] shift_q;
    logic        accept;

    assign accept = (state == IDLE) && ReqReady && ReqValid;

    function automatic logic [1:0] last_of(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_error(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || (addr >= 32'(MEM_DEPTH));
    endfunction

    // Byte i of an N-byte datum, most significant byte first.
    function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] last,
                                            input logic [1:0] i);
        logic [31:0] s;
        s = d >> {last - i, 3'b000};
        return s[7:0];
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'b00:   return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            2'b01:   return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 2'd0;
            ReqReady     <= 1'b0;
            RespValid    <= 1'b0;
            RespError    <= 1'b0;
            RespData     <= 32'h0;
            MemAddress   <= '0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            MemWriteByte <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ReqReady <= 1'b0;
                        if (is_error(ReqSize, ReqAddress)) begin
                            RespValid <= 1'b1;
                            RespError <= 1'b1;
                            RespData  <= 32'h0;
                            state     <= RESP;
                        end else begin
                            idx          <= 2'd0;
                            MemAddress   <= ReqAddress[ADDR_W-1:0];
                            MemWrite     <= ReqWrite;
                            MemRead      <= !ReqWrite;
                            MemWriteByte <= byte_sel(ReqWriteData, last_of(ReqSize), 2'd0);
                            state        <= ACCESS;
                        end
                    end else begin
                        ReqReady <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (idx == last_q) begin
                        MemWrite <= 1'b0;
                        MemRead  <= 1'b0;
                        if (write_q) begin
                            RespValid <= 1'b1;
                            RespError <= 1'b0;
                            RespData  <= 32'h0;
                            state     <= RESP;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx          <= idx + 2'd1;
                        MemAddress   <= MemAddress + ADDR_W'(1);
                        MemWriteByte <= byte_sel(wdata_q, last_q, idx + 2'd1);
                    end
                end
                // Final read byte is still on MemReadByte here; fold it in directly.
                DRAIN: begin
                    RespValid <= 1'b1;
                    RespError <= 1'b0;
                    RespData  <= extend({shift_q, MemReadByte}, size_q, signed_q);
                    state     <= RESP;
                end
                RESP: begin
                    RespValid <= 1'b0;
                    RespError <= 1'b0;
                    RespData  <= 32'h0;
                    ReqReady  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Captured request and read assembly; byte k arrives one cycle after its strobe.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= ReqWrite;
            signed_q <= ReqSigned;
            size_q   <= ReqSize;
            last_q   <= last_of(ReqSize);
            wdata_q  <= ReqWriteData;
            shift_q  <= 24'h0;
        end else if (state == ACCESS && !write_q && idx != 2'd0) begin
            shift_q <= {shift_q[15:0], MemReadByte};
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: byte memory model, fixed vector table, corner
// sequences and randomized traffic checked against a transaction-level reference.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [31:0] ReqAddress = 32'h0;
    logic [31:0] ReqWriteData = 32'h0;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespError;
    logic [9:0]  MemAddress;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  MemWriteByte;
    logic [7:0]  MemReadByte;

    logic [7:0]  mem [0:1023];
    logic [7:0]  ref_mem [0:1023];
    int          passed = 0;
    int          total = 0;

    mem_access_sequencer #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
        .ReqWriteData(ReqWriteData), .RespValid(RespValid), .RespData(RespData),
        .RespError(RespError), .MemAddress(MemAddress), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemWriteByte(MemWriteByte), .MemReadByte(MemReadByte)
    );

    always #5 clk = ~clk;

    // Registered byte memory: read data appears the cycle after MemRead.
    initial begin
        MemReadByte = 8'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            if (MemWrite) mem[MemAddress] <= MemWriteByte;
            if (MemRead) MemReadByte <= mem[MemAddress];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Transaction-level reference: resolves a whole access against ref_mem at once.
    function automatic void ref_access(input bit wr, input bit [1:0] sz, input bit sg,
                                       input bit [31:0] a, input bit [31:0] wd,
                                       output bit [31:0] data, output bit err);
        int n;
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (a >= 32'd1024);
        data = 32'h0;
        if (err) return;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            if (wr) ref_mem[int'(a[9:0]) + k] = 8'(wd >> (8 * (n - 1 - k)));
            else data = (data << 8) | 32'(ref_mem[int'(a[9:0]) + k]);
        end
        if (!wr && sg && n == 1 && data[7]) data = data | 32'hFFFFFF00;
        if (!wr && sg && n == 2 && data[15]) data = data | 32'hFFFF0000;
        if (wr) data = 32'h0;
    endfunction

    // Issue one request starting at a negedge; checks every cycle until ReqReady returns.
    task automatic run_req(input string name, input bit wr, input bit [1:0] sz, input bit sg,
                           input bit [31:0] a, input bit [31:0] wd, input bit [31:0] ed,
                           input bit ee, input bit hold, output int waited);
        int n, lat;
        bit act;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        lat = ee ? 1 : (wr ? n + 1 : n + 2);
        waited = 0;
        while (!ReqReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ReqReady) begin
            chk({name, "/ready_timeout"}, 32'(ReqReady), 32'd1);
            return;
        end
        ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddress = a; ReqWriteData = wd;
        ReqValid = 1'b1;
        @(posedge clk);
        #1;
        ReqValid = hold; ReqWrite = 1'($urandom); ReqSize = 2'($urandom);
        ReqSigned = 1'($urandom); ReqAddress = $urandom; ReqWriteData = $urandom;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            act = !ee && (c <= n);
            chk({name, "/strobes"}, 32'({MemWrite, MemRead}), 32'({act && wr, act && !wr}));
            if (act) begin
                chk({name, "/addr"}, 32'(MemAddress), 32'(a[9:0]) + 32'(c - 1));
                if (wr) chk({name, "/wbyte"}, 32'(MemWriteByte), 32'(8'(wd >> (8 * (n - c)))));
            end
            chk({name, "/resp_valid"}, 32'(RespValid), 32'(c == lat));
            if (c == lat) begin
                chk({name, "/resp_error"}, 32'(RespError), 32'(ee));
                chk({name, "/resp_data"}, RespData, ed);
            end
            chk({name, "/ready"}, 32'(ReqReady), 32'(c == lat + 1));
        end
        ReqValid = 1'b0;
    endtask

    typedef struct {
        bit        wr;
        bit [1:0]  sz;
        bit        sg;
        bit [31:0] a;
        bit [31:0] wd;
        bit [31:0] ed;
        bit        ee;
    } vec_t;

    vec_t vecs [16];

    task automatic check_all_zero(input string name);
        chk({name, "/ReqReady"}, 32'(ReqReady), 32'd0);
        chk({name, "/RespValid"}, 32'(RespValid), 32'd0);
        chk({name, "/RespError"}, 32'(RespError), 32'd0);
        chk({name, "/RespData"}, RespData, 32'd0);
        chk({name, "/MemWrite"}, 32'(MemWrite), 32'd0);
        chk({name, "/MemRead"}, 32'(MemRead), 32'd0);
        chk({name, "/MemAddress"}, 32'(MemAddress), 32'd0);
        chk({name, "/MemWriteByte"}, 32'(MemWriteByte), 32'd0);
    endtask

    initial begin
        bit [31:0] ed;
        bit        ee;
        bit [31:0] dummy_d;
        bit        dummy_e;
        int        waited;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFBE, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000BE, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000DEAD, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h80000010, 32'h12345678, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h40, 32'h1234ABCD, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFFABCD, 1'b0};
        vecs[14] = '{1'b1, 2'b00, 1'b0, 32'h43, 32'hFFFFFF7F, 32'h0, 1'b0};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 32'h0000007F, 1'b0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);

        // Reset state, asynchronous release behaviour.
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 32'(ReqReady), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(ReqReady), 32'd1);

        for (int v = 0; v < 16; v++) begin
            ref_access(vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].a, vecs[v].wd,
                       dummy_d, dummy_e);
            run_req($sformatf("vec%0d", v), vecs[v].wr, vecs[v].sz, vecs[v].sg, vecs[v].a,
                    vecs[v].wd, vecs[v].ed, vecs[v].ee, 1'b0, waited);
        end

        // Reset during the third byte of a word store.
        ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
        ReqAddress = 32'h20; ReqWriteData = 32'h11223344; ReqValid = 1'b1;
        @(posedge clk);
        #1;
        ReqValid = 1'b0; ReqAddress = 32'h3C; ReqWriteData = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midrst/pre_write", 32'(MemWrite), 32'd1);
        chk("midrst/pre_addr", 32'(MemAddress), 32'h22);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst/ready_low", 32'(ReqReady), 32'd0);
        @(negedge clk);
        chk("midrst/ready_high", 32'(ReqReady), 32'd1);
        ref_mem[32'h20] = 8'h11;
        ref_mem[32'h21] = 8'h22;
        ref_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, ed, ee);
        run_req("midrst_lw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, ed, ee, 1'b0, waited);

        // Back-to-back with ReqValid held high across the busy window.
        ref_access(1'b1, 2'b00, 1'b0, 32'h05, 32'hA5, dummy_d, dummy_e);
        run_req("b2b_sb", 1'b1, 2'b00, 1'b0, 32'h05, 32'h000000A5, 32'h0, 1'b0, 1'b1, waited);
        ref_access(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, dummy_d, dummy_e);
        run_req("b2b_lbu", 1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'h000000A5, 1'b0, 1'b1, waited);
        chk("b2b/no_wait", 32'(waited), 32'd0);

        // Randomized traffic against the reference.
        for (int t = 0; t < 150; t++) begin
            bit        wr, sg;
            bit [1:0]  sz;
            bit [31:0] a, wd;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            wd = $urandom;
            ref_access(wr, sz, sg, a, wd, ed, ee);
            run_req($sformatf("rand%0d", t), wr, sz, sg, a, wd, ed, ee,
                    1'($urandom_range(0, 1)), waited);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
